// File: rtl/i2c_poll_pkg.sv
// Shared definitions for the I2C poll sequencer.
// Holds the sequencer state encoding, the width of one FIFO sample entry
// ({error, byte}) and the saturation ceiling of the error counter.
package i2c_poll_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ARM        = 3'd1,
    SETTLE     = 3'd2,
    KICK       = 3'd3,
    WAIT_START = 3'd4,
    WAIT_DONE  = 3'd5,
    CAPTURE    = 3'd6
  } poll_state_e;

  localparam int SAMPLE_W = 9;
  localparam logic [7:0] ERR_COUNT_MAX = 8'd255;

  // Increment that sticks at ERR_COUNT_MAX instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == ERR_COUNT_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/poll_sample_fifo.sv
// Small synchronous FIFO holding captured {error, byte} samples.
// Ports:
//   clk, reset      - clock and synchronous active-high reset (empties FIFO)
//   push, push_data - write request and entry
//   pop             - read request; ignored while empty
//   head_data       - oldest entry, forced to 0 while empty
//   empty, full     - occupancy flags from the registered count
// A push while full is accepted only if a pop retires the head in the same
// cycle; otherwise it is silently dropped (the caller tracks that).
module poll_sample_fifo
  import i2c_poll_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = SAMPLE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  // Pointers rely on DEPTH being a power of two so they wrap for free.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/i2c_poll_sequencer.sv
// Periodic poller for the single-byte I2C register reader.
// Every POLL_INTERVAL idle cycles it pulses the reader's active-low reset,
// waits for the reader to finish setup, kicks it with a one-cycle enable,
// waits for the transaction to end and pushes {error, byte} into a sample FIFO.
// Ports:
//   clk, reset                        - clock, synchronous active-high reset
//   run                               - polling enable (finishes current poll)
//   rd_reset_n, rd_enable             - reader reset and start pulse (registered)
//   rd_busy, rd_recv_buf, rd_error    - reader status and result
//   sample_data/err/valid, sample_ready - FIFO head with valid/ready handshake
//   overflow                          - sticky, a sample was dropped on full
//   err_count                         - saturating count of errored samples
// Optional build macro I2C_POLL_TIMEOUT_EN bounds every wait state to
// TIMEOUT_CYCLES and reports an expired wait as sample 0x00 with error set.
module i2c_poll_sequencer
  import i2c_poll_pkg::*;
#(
  parameter int POLL_INTERVAL  = 100000,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  output logic       rd_reset_n,
  output logic       rd_enable,
  input  logic       rd_busy,
  input  logic [7:0] rd_recv_buf,
  input  logic       rd_error,
  output logic [7:0] sample_data,
  output logic       sample_err,
  output logic       sample_valid,
  input  logic       sample_ready,
  output logic       overflow,
  output logic [7:0] err_count
);

  if (POLL_INTERVAL < 1) begin : g_bad_interval
    $error("POLL_INTERVAL must be at least 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end

  localparam int IW = $clog2(POLL_INTERVAL + 1);
  localparam logic [IW-1:0] INTERVAL_LAST = IW'(POLL_INTERVAL - 1);

  poll_state_e   state_q, state_d;
  logic [IW-1:0] interval_q, interval_d;
  logic [7:0]    err_count_q, err_count_d;
  logic          overflow_q, overflow_d;
  logic          rd_reset_n_q, rd_reset_n_d;
  logic          rd_enable_q, rd_enable_d;
  logic          settle_armed_q, settle_armed_d;
  logic          in_wait, wait_expired;
  logic          cap_err;
  logic [7:0]    cap_byte;
  logic          fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [SAMPLE_W-1:0] fifo_head;

  assign in_wait = (state_q == SETTLE) || (state_q == WAIT_START) ||
                   (state_q == WAIT_DONE);

`ifdef I2C_POLL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic          timed_out_q, timed_out_d;

  assign wait_expired = in_wait && (wait_cnt_q == TIMEOUT_LAST);

  // The wait counter restarts on every state change so each wait state gets
  // its own full budget. timed_out_q marks the CAPTURE cycle it caused.
  always_comb begin
    wait_cnt_d  = '0;
    timed_out_d = wait_expired;
    if (in_wait && (state_d == state_q)) begin
      wait_cnt_d = wait_cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q  <= '0;
      timed_out_q <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign cap_err  = timed_out_q || rd_error;
  assign cap_byte = timed_out_q ? 8'h00 : rd_recv_buf;
`else
  assign wait_expired = 1'b0;
  assign cap_err      = rd_error;
  assign cap_byte     = rd_recv_buf;
`endif

  // Sequencer. Outputs are decoded from the next state and registered, so
  // rd_reset_n is low exactly while the state register holds ARM and
  // rd_enable is high exactly while it holds KICK.
  always_comb begin
    state_d     = state_q;
    interval_d  = interval_q;
    err_count_d = err_count_q;
    fifo_push   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!run) begin
          interval_d = '0;
        end else if (interval_q == INTERVAL_LAST) begin
          interval_d = '0;
          state_d    = ARM;
        end else begin
          interval_d = interval_q + IW'(1);
        end
      end
      ARM: state_d = SETTLE;
      SETTLE: begin
        // The reader reports busy during its setup cycle right after reset.
        if (wait_expired) state_d = CAPTURE;
        else if (settle_armed_q && !rd_busy) state_d = KICK;
      end
      KICK: state_d = WAIT_START;
      WAIT_START: begin
        if (wait_expired) state_d = CAPTURE;
        else if (rd_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (wait_expired || !rd_busy) state_d = CAPTURE;
      end
      CAPTURE: begin
        fifo_push  = 1'b1;
        state_d    = IDLE;
        interval_d = '0;
        if (cap_err) err_count_d = sat_inc(err_count_q);
      end
      default: state_d = IDLE;
    endcase
  end

  // A dropped sample still counts toward err_count above; here it only
  // raises the sticky overflow flag.
  always_comb begin
    settle_armed_d = (state_q == SETTLE);
    rd_reset_n_d   = (state_d != ARM);
    rd_enable_d    = (state_d == KICK);
    overflow_d     = overflow_q || (fifo_push && fifo_full && !fifo_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      interval_q     <= '0;
      err_count_q    <= '0;
      overflow_q     <= 1'b0;
      rd_reset_n_q   <= 1'b0;
      rd_enable_q    <= 1'b0;
      settle_armed_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      interval_q     <= interval_d;
      err_count_q    <= err_count_d;
      overflow_q     <= overflow_d;
      rd_reset_n_q   <= rd_reset_n_d;
      rd_enable_q    <= rd_enable_d;
      settle_armed_q <= settle_armed_d;
    end
  end

  assign fifo_pop = !fifo_empty && sample_ready;

  poll_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({cap_err, cap_byte}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign rd_reset_n   = rd_reset_n_q;
  assign rd_enable    = rd_enable_q;
  assign sample_valid = !fifo_empty;
  assign sample_err   = fifo_head[8];
  assign sample_data  = fifo_head[7:0];
  assign overflow     = overflow_q;
  assign err_count    = err_count_q;

endmodule
